freq_reporter: RTL
==================

# freq_reporter

Upstream framing stage for the UART transmit path. Accepts 32-bit frequency measurements from the counter core, buffers them in a small FIFO, and turns each into a serial frame of header, value bytes LSB first, and optional checksum. It drives the multi-byte transmitter's `start`/`word`/`bytes`/`busy` handshake as two back-to-back transfers per frame.

## Interface
- `DEPTH`, 4: FIFO entries; must be a power of two, ≥2.
- `HEADER`, 8'hA5: frame sync byte.

- `clk` in 1: system clock, all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `meas_valid` in 1: one-cycle strobe; `meas_value` is pushed into the FIFO.
- `meas_value` in 32: measured count.
- `overflow_clr` in 1: clears `overflow`.
- `fifo_full` out 1: FIFO count == DEPTH (registered count).
- `overflow` out 1: sticky; set when a push is dropped.
- `tx_start` out 1: start strobe to the transmitter.
- `tx_word` out 32: word to send, LSB byte first.
- `tx_bytes` out 3: number of bytes of `tx_word` to send.
- `tx_busy` in 1: transmitter busy. Rises one cycle after `tx_start` is accepted and stays high until all bytes are sent.
- `frames_sent` out 16: completed-frame counter, wraps at 0xFFFF→0.

## Operation
- **FIFO push:** a push on `meas_valid` is accepted when count < DEPTH, or when a pop occurs in the same cycle.
  - Otherwise the value is dropped and `overflow` is set.
  - If set and clear occur in the same cycle, set wins.
- **Pop:** occurs only in IDLE. The popped value is latched into the frame register `v`.
- **Checksum:** `chk = HEADER ^ v[7:0] ^ v[15:8] ^ v[23:16] ^ v[31:24]`.
- **Transfer A:** `tx_word = {v[23:0], HEADER}`, `tx_bytes = 4`.
- **Transfer B:** `tx_word = {16'h0, chk, v[31:24]}`, `tx_bytes = 2`.
- **States:**
  - IDLE: when FIFO non-empty and `tx_busy` = 0, pop and go to START_A.
  - START_A: `tx_start` = 1 for exactly one cycle; go to WAIT_HI_A.
  - WAIT_HI_A: `tx_start` = 0; when `tx_busy` = 1, go to WAIT_LO_A.
  - WAIT_LO_A: when `tx_busy` = 0, go to START_B.
  - START_B, WAIT_HI_B, WAIT_LO_B: same as the A states, using transfer B.
  - On WAIT_LO_B exit, `frames_sent` increments and the FSM returns to IDLE.
- Illegal state encodings go to IDLE.
- `tx_word` and `tx_bytes` are registered and held stable from START_x until the next START.
- `meas_valid` is honoured in every state, including mid-frame.
- **Reset:** asynchronous and may occur mid-frame.
  - All outputs go to 0: `tx_start`, `tx_word`, `tx_bytes`, `fifo_full`, `overflow`, `frames_sent`.
  - The FIFO is emptied and the FSM goes to IDLE.
  - Any partial frame is abandoned and is not resent.

## Timing
- FIFO non-empty in cycle N with `tx_busy` = 0 → pop at N, `tx_start` high at N+1.
- Push at cycle N is visible to the IDLE pop at cycle N+1. Minimum latency from `meas_valid` to `tx_start` is 2 cycles.
- Transfer B starts exactly 1 cycle after WAIT_LO_A sees `tx_busy` = 0.
- `frames_sent` updates the cycle after WAIT_LO_B sees `tx_busy` = 0.
- A `tx_busy` that never rises stalls the FSM in WAIT_HI_x. No timeout.

## Configuration
- `FREQ_REPORTER_CHECKSUM_EN` defined: 6-byte frame. Transfer B has `tx_bytes = 2` and carries `chk`.
- Undefined: 5-byte frame. Transfer B has `tx_word = {24'h0, v[31:24]}`, `tx_bytes = 1`, and no checksum logic is synthesised.

## Test plan
- **Single frame:** push 0x12345678 with macro defined, bench transmitter model on `tx_busy`. Expect transfer A word 0x345678A5 / bytes 4, then transfer B word 0x0000AD12 / bytes 2, and `frames_sent` = 1.
- **Checksum disabled:** same push with the macro undefined. Expect transfer B word 0x00000012 / bytes 1.
- **Overflow:** DEPTH = 4, hold `tx_busy` = 1, push 6 values.
  - Expect `fifo_full` = 1 after the 4th push and `overflow` = 1 after the 5th.
  - Release `tx_busy`: exactly 4 frames are sent, in push order.
  - Pulse `overflow_clr`: `overflow` = 0.
- **Push while full with same-cycle pop:** FIFO full, `meas_valid` coincides with the IDLE pop. Expect the push accepted and `overflow` still 0.
- **Reset mid-frame:** assert `rst` during WAIT_LO_A with 2 entries queued. Expect all outputs 0 immediately, and no `tx_start` after release until a new push arrives.
- **Counter wrap:** preload or run frames until `frames_sent` = 0xFFFF, then complete one more frame. Expect `frames_sent` = 0x0000.

Source files
------------

// File: rtl/freq_reporter.sv
// freq_reporter: buffers 32-bit frequency counts and frames each one as header, LSB-first value bytes and an optional XOR checksum.
// Define FREQ_REPORTER_CHECKSUM_EN for the 6-byte frame with checksum; without it the frame is 5 bytes.
module freq_reporter #(
  parameter int unsigned DEPTH  = 4,
  parameter logic [7:0]  HEADER = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        meas_valid,
  input  logic [31:0] meas_value,
  input  logic        overflow_clr,
  output logic        fifo_full,
  output logic        overflow,
  output logic        tx_start,
  output logic [31:0] tx_word,
  output logic [2:0]  tx_bytes,
  input  logic        tx_busy,
  output logic [15:0] frames_sent
);
  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START_A   = 3'd1,
    WAIT_HI_A = 3'd2,
    WAIT_LO_A = 3'd3,
    START_B   = 3'd4,
    WAIT_HI_B = 3'd5,
    WAIT_LO_B = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   head;
  logic [7:0]    v_top_q, v_top_d;
  logic [31:0]   tx_word_q, tx_word_d, word_b;
  logic [2:0]    tx_bytes_q, tx_bytes_d, bytes_b;
  logic          tx_start_q, tx_start_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   frames_sent_q, frames_sent_d;
  logic          pop, push_ok;

  assign head = mem_q[rd_ptr_q];

`ifdef FREQ_REPORTER_CHECKSUM_EN
  logic [7:0] chk_q, chk_d;

  always_comb begin
    chk_d = chk_q;
    if (pop) chk_d = HEADER ^ head[7:0] ^ head[15:8] ^ head[23:16] ^ head[31:24];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) chk_q <= '0;
    else     chk_q <= chk_d;
  end

  assign word_b  = {16'h0, chk_q, v_top_q};
  assign bytes_b = 3'd2;
`else
  assign word_b  = {24'h0, v_top_q};
  assign bytes_b = 3'd1;
`endif

  always_comb begin
    state_d       = state_q;
    v_top_d       = v_top_q;
    tx_word_d     = tx_word_q;
    tx_bytes_d    = tx_bytes_q;
    tx_start_d    = 1'b0;
    frames_sent_d = frames_sent_q;
    pop           = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0 && !tx_busy) begin
          pop        = 1'b1;
          v_top_d    = head[31:24];
          tx_word_d  = {head[23:0], HEADER};
          tx_bytes_d = 3'd4;
          tx_start_d = 1'b1;
          state_d    = START_A;
        end
      end
      START_A:   state_d = WAIT_HI_A;
      WAIT_HI_A: if (tx_busy) state_d = WAIT_LO_A;
      WAIT_LO_A: begin
        if (!tx_busy) begin
          tx_word_d  = word_b;
          tx_bytes_d = bytes_b;
          tx_start_d = 1'b1;
          state_d    = START_B;
        end
      end
      START_B:   state_d = WAIT_HI_B;
      WAIT_HI_B: if (tx_busy) state_d = WAIT_LO_B;
      WAIT_LO_B: begin
        if (!tx_busy) begin
          frames_sent_d = frames_sent_q + 16'd1;
          state_d       = IDLE;
        end
      end
      default:   state_d = IDLE;
    endcase
  end

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    push_ok    = meas_valid && (count_q != FULL_CNT || pop);
    rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    wr_ptr_d   = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    count_d    = count_q;
    if (push_ok && !pop)      count_d = count_q + 1'b1;
    else if (!push_ok && pop) count_d = count_q - 1'b1;
    overflow_d = overflow_clr ? 1'b0 : overflow_q;
    if (meas_valid && !push_ok) overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= meas_value;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      v_top_q       <= '0;
      tx_word_q     <= '0;
      tx_bytes_q    <= '0;
      tx_start_q    <= 1'b0;
      overflow_q    <= 1'b0;
      frames_sent_q <= '0;
    end else begin
      state_q       <= state_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      v_top_q       <= v_top_d;
      tx_word_q     <= tx_word_d;
      tx_bytes_q    <= tx_bytes_d;
      tx_start_q    <= tx_start_d;
      overflow_q    <= overflow_d;
      frames_sent_q <= frames_sent_d;
    end
  end

  assign fifo_full   = (count_q == FULL_CNT);
  assign overflow    = overflow_q;
  assign tx_start    = tx_start_q;
  assign tx_word     = tx_word_q;
  assign tx_bytes    = tx_bytes_q;
  assign frames_sent = frames_sent_q;
endmodule
